// File: rtl/rx_majority_sampler.sv
// rtl/rx_majority_sampler.sv - UART RX oversampling data sampler with majority vote
module rx_majority_sampler #(
    parameter int SAMPLES    = 3,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  DataSampler_Enable,
    input  logic [PRESCALE_W-1:0] Edge_Counts,
    input  logic                  Serial_Data,
    input  logic [PRESCALE_W-1:0] PreScale,
    output logic                  Sampled_Bit,
    output logic                  Sample_Valid,
    output logic                  Noise_Err,
    output logic [2:0]            Ones_Count,
    output logic                  Cfg_Err
);

    // Edge arithmetic is one bit wider than PreScale so CTR+HALF+1 never wraps.
    localparam int EW   = PRESCALE_W + 1;
    localparam int HALF = (SAMPLES - 1) / 2;

    localparam logic [EW-1:0] L_HALF_E    = EW'(HALF);
    localparam logic [EW-1:0] L_MIN_PS    = EW'(SAMPLES + 3);
    localparam logic [2:0]    L_HALF_C    = 3'(HALF);
    localparam logic [2:0]    L_SAMPLES_C = 3'(SAMPLES);

    logic [EW-1:0]      w_ps_ext;
    logic [EW-1:0]      w_edge_ext;
    logic [EW-1:0]      w_ctr;
    logic [EW-1:0]      w_lo;
    logic [EW-1:0]      w_dec;
    logic [SAMPLES-1:0] w_hit;
    logic               w_at_dec;
    logic               w_mask_full;
    logic [2:0]         w_pop;
    logic               w_decide;
    logic               w_abort_bit;

    logic [SAMPLES-1:0] r_sample;
    logic [SAMPLES-1:0] r_mask;

    // Window geometry: centre edge, first window edge and decision edge.
    always_comb begin
        w_ps_ext   = {1'b0, PreScale};
        w_edge_ext = {1'b0, Edge_Counts};
        w_ctr      = w_ps_ext >> 1;
        w_lo       = w_ctr - L_HALF_E;
        w_dec      = w_ctr + L_HALF_E + EW'(1);
    end

    // PreScale must be even and leave room for the window plus the decide edge.
    always_comb begin
        Cfg_Err = PreScale[0] | (w_ps_ext < L_MIN_PS);
    end

    // One-hot match of the current edge against each sample slot in the window.
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < SAMPLES; k++) begin
            w_hit[k] = (w_edge_ext == (w_lo + EW'(k)));
        end
    end

    // Decision-edge detection and completeness of the captured window.
    always_comb begin
        w_at_dec    = (w_edge_ext == w_dec);
        w_mask_full = &r_mask;
        w_decide    = DataSampler_Enable & ~Cfg_Err & w_at_dec & w_mask_full;
        w_abort_bit = DataSampler_Enable & ~Cfg_Err & w_at_dec & ~w_mask_full;
    end

    // Number of ones among the captured samples.
    always_comb begin
        w_pop = '0;
        for (int k = 0; k < SAMPLES; k++) begin
            w_pop = w_pop + {2'b00, r_sample[k]};
        end
    end

    // Sample register and capture mask: fill in the window, clear at decide or when idle.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_sample <= '0;
            r_mask   <= '0;
        end else if (Cfg_Err) begin
            r_sample <= r_sample;
            r_mask   <= r_mask;
        end else if (!DataSampler_Enable) begin
            r_sample <= '0;
            r_mask   <= '0;
        end else if (w_at_dec) begin
            r_mask   <= '0;
        end else begin
            for (int k = 0; k < SAMPLES; k++) begin
                if (w_hit[k]) begin
                    r_sample[k] <= Serial_Data;
                    r_mask[k]   <= 1'b1;
                end
            end
        end
    end

    // Resolved-bit outputs: update only on a complete decision, otherwise hold.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            Sampled_Bit  <= 1'b0;
            Sample_Valid <= 1'b0;
            Noise_Err    <= 1'b0;
            Ones_Count   <= 3'd0;
        end else if (w_decide) begin
            Sampled_Bit  <= (w_pop > L_HALF_C);
            Sample_Valid <= 1'b1;
            Noise_Err    <= (w_pop != 3'd0) && (w_pop != L_SAMPLES_C);
            Ones_Count   <= w_pop;
        end else begin
            Sample_Valid <= 1'b0;
        end
    end

    // An incomplete window at the decide edge is dropped silently; outputs hold.
    logic w_unused;
    always_comb begin
        w_unused = w_abort_bit;
    end

endmodule
